// File: rtl/rename_pkg.sv
// Shared types and sizes for the register-rename stage.
package rename_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int PREG_W    = $clog2(PHYS_REGS);
  localparam int PAYLOAD_W = 48;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [4:0]        areg_t;

  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] imm;
    logic        alusrc;
    logic        branch;
    logic [1:0]  aluop;
    logic        futype;
    logic        memread;
    logic        memwrite;
  } rename_payload_t;

endpackage

// File: rtl/rename_stage_if.sv
// Decode-side, dispatch-side and commit-free signals of the rename stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and data stable until that edge.
interface rename_stage_if;
  import rename_pkg::*;

  logic            i_valid;
  logic            o_ready;
  areg_t           i_rs1;
  areg_t           i_rs2;
  areg_t           i_rd;
  logic            i_Regwrite;
  rename_payload_t i_payload;

  logic            o_valid;
  logic            i_ready;
  preg_t           o_prs1;
  preg_t           o_prs2;
  preg_t           o_prd;
  preg_t           o_old_prd;
  logic            o_Regwrite;
  rename_payload_t o_payload;

  logic            free_valid;
  preg_t           free_preg;

  logic [PREG_W:0] dbg_free_count;

  modport master (
    output i_valid, i_rs1, i_rs2, i_rd, i_Regwrite, i_payload, i_ready,
           free_valid, free_preg,
    input  o_ready, o_valid, o_prs1, o_prs2, o_prd, o_old_prd, o_Regwrite,
           o_payload, dbg_free_count
  );

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rd, i_Regwrite, i_payload, i_ready,
           free_valid, free_preg,
    output o_ready, o_valid, o_prs1, o_prs2, o_prd, o_old_prd, o_Regwrite,
           o_payload, dbg_free_count
  );
endinterface

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical registers; preloaded with p32..p63 on reset.
module free_list
  import rename_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            pop_i,
  input  logic            push_i,
  input  preg_t           push_preg_i,
  output preg_t           head_preg_o,
  output logic            empty_o,
  output logic [PREG_W:0] count_o
);

  localparam logic [PREG_W:0] FULL_COUNT = (PREG_W+1)'(PHYS_REGS - 1);

  preg_t           fifo_q [PHYS_REGS];
  preg_t           head_q, head_d;
  preg_t           tail_q, tail_d;
  logic [PREG_W:0] count_q, count_d;
  logic            do_pop, do_push;

  assign empty_o     = (count_q == '0);
  assign head_preg_o = fifo_q[head_q];
  assign count_o     = count_q;

  // p0 is never handed out, so at most PHYS_REGS-1 entries can be live.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (push_preg_i != '0) && (count_q != FULL_COUNT);

  always_comb begin
    head_d  = head_q + preg_t'(do_pop);
    tail_d  = tail_q + preg_t'(do_push);
    count_d = count_q + {{PREG_W{1'b0}}, do_push} - {{PREG_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        fifo_q[i] <= (i < ARCH_REGS) ? preg_t'(i + ARCH_REGS) : '0;
      end
      head_q  <= '0;
      tail_q  <= preg_t'(ARCH_REGS);
      count_q <= (PREG_W+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      if (do_push) fifo_q[tail_q] <= push_preg_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: speculative map table, free list and one registered output slot.
module rename_stage
  import rename_pkg::*;
(
  input logic          clk,
  input logic          reset,
  rename_stage_if.slave bus
);

  preg_t           map_q [ARCH_REGS];
  logic            needs_alloc, accept, fl_empty;
  preg_t           fl_head;
  logic [PREG_W:0] fl_count;

  logic            o_valid_q, o_valid_d;
  preg_t           o_prs1_q, o_prs1_d;
  preg_t           o_prs2_q, o_prs2_d;
  preg_t           o_prd_q, o_prd_d;
  preg_t           o_old_prd_q, o_old_prd_d;
  logic            o_regwrite_q, o_regwrite_d;
  rename_payload_t o_payload_q, o_payload_d;

  assign needs_alloc = bus.i_Regwrite && (bus.i_rd != '0);
  assign bus.o_ready = (!o_valid_q || bus.i_ready) && (!needs_alloc || !fl_empty);
  assign accept      = bus.i_valid && bus.o_ready;

  free_list u_free_list (
    .clk         (clk),
    .reset       (reset),
    .pop_i       (accept && needs_alloc),
    .push_i      (bus.free_valid),
    .push_preg_i (bus.free_preg),
    .head_preg_o (fl_head),
    .empty_o     (fl_empty),
    .count_o     (fl_count)
  );

  // Sources read the pre-update map so rs==rd sees the older producer.
  always_comb begin
    o_valid_d    = o_valid_q;
    o_prs1_d     = o_prs1_q;
    o_prs2_d     = o_prs2_q;
    o_prd_d      = o_prd_q;
    o_old_prd_d  = o_old_prd_q;
    o_regwrite_d = o_regwrite_q;
    o_payload_d  = o_payload_q;
    if (accept) begin
      o_valid_d    = 1'b1;
      o_prs1_d     = map_q[bus.i_rs1];
      o_prs2_d     = map_q[bus.i_rs2];
      o_prd_d      = needs_alloc ? fl_head : '0;
      o_old_prd_d  = needs_alloc ? map_q[bus.i_rd] : '0;
      o_regwrite_d = needs_alloc;
      o_payload_d  = bus.i_payload;
    end else if (bus.i_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= preg_t'(i);
      o_valid_q    <= 1'b0;
      o_prs1_q     <= '0;
      o_prs2_q     <= '0;
      o_prd_q      <= '0;
      o_old_prd_q  <= '0;
      o_regwrite_q <= 1'b0;
      o_payload_q  <= '0;
    end else begin
      if (accept && needs_alloc) map_q[bus.i_rd] <= fl_head;
      o_valid_q    <= o_valid_d;
      o_prs1_q     <= o_prs1_d;
      o_prs2_q     <= o_prs2_d;
      o_prd_q      <= o_prd_d;
      o_old_prd_q  <= o_old_prd_d;
      o_regwrite_q <= o_regwrite_d;
      o_payload_q  <= o_payload_d;
    end
  end

  assign bus.o_valid        = o_valid_q;
  assign bus.o_prs1         = o_prs1_q;
  assign bus.o_prs2         = o_prs2_q;
  assign bus.o_prd          = o_prd_q;
  assign bus.o_old_prd      = o_old_prd_q;
  assign bus.o_Regwrite     = o_regwrite_q;
  assign bus.o_payload      = o_payload_q;
  assign bus.dbg_free_count = fl_count;

endmodule
